// File: rtl/scoreboard_hazard_unit.sv
// Load-use hazard unit with a per-register pending scoreboard for variable-latency loads.
// Optional macro SCOREBOARD_WB_BYPASS_EN: a same-cycle writeback releases the hazard it resolves.
module scoreboard_hazard_unit #(
    parameter int REG_ADDR_W      = 5,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STALL_CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic                   id_use_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_use_rs2,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   flush,
    input  logic                   wb_valid,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    output logic                   PC_write,
    output logic                   IF_ID_write,
    output logic                   control_op,
    output logic [1:0]             stall_cause,
    output logic [3:0]             outstanding,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   wb_underflow_err
);

    localparam int         NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [3:0] MAX_OUT  = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_RAW    = 2'b01,
        CAUSE_WAW    = 2'b10,
        CAUSE_STRUCT = 2'b11
    } cause_e;

    logic [NUM_REGS-1:0]    r_pending;
    logic [3:0]             r_outstanding;
    logic [STALL_CNT_W-1:0] r_stall_cycles;
    logic                   r_wb_underflow_err;

    logic [NUM_REGS-1:0]    w_wb_mask;
    logic [NUM_REGS-1:0]    w_p_eff;
    logic [NUM_REGS-1:0]    w_pending_next;
    logic                   w_wb_free;
    logic                   w_raw;
    logic                   w_waw;
    logic                   w_struct;
    logic                   w_live;
    logic                   w_stall;
    logic                   w_issue;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_wb_mask = '0;
        if (wb_valid) w_wb_mask[wb_rd] = 1'b1;
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign w_p_eff   = r_pending & ~w_wb_mask & ~NUM_REGS'(1);
    assign w_wb_free = wb_valid && (r_outstanding != 4'd0);
`else
    assign w_p_eff   = r_pending & ~NUM_REGS'(1);
    assign w_wb_free = 1'b0;
`endif

    assign w_raw    = (id_use_rs1 && w_p_eff[id_rs1]) || (id_use_rs2 && w_p_eff[id_rs2]);
    assign w_waw    = id_reg_write && (id_rd != '0) && w_p_eff[id_rd];
    assign w_struct = id_mem_read && (r_outstanding == MAX_OUT) && !w_wb_free;
    // A squashed instruction neither stalls nor issues; reset masks everything.
    assign w_live   = reset_n && id_valid && !flush;
    assign w_stall  = w_live && (w_raw || w_waw || w_struct);
    assign w_issue  = w_live && !w_stall && id_mem_read;

    always_comb begin
        stall_cause = CAUSE_NONE;
        if (w_stall) begin
            if (w_raw)      stall_cause = CAUSE_RAW;
            else if (w_waw) stall_cause = CAUSE_WAW;
            else            stall_cause = CAUSE_STRUCT;
        end
    end

    // The issuing load's set is applied after the writeback clear, so it wins on the same index.
    always_comb begin
        w_pending_next = r_pending & ~w_wb_mask;
        if (w_issue && (id_rd != '0)) w_pending_next[id_rd] = 1'b1;
    end

    // NOTE: state uses non-blocking assignments; the scoreboard is plain flops, so reset clears it too.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending          <= '0;
            r_outstanding      <= 4'd0;
            r_stall_cycles     <= '0;
            r_wb_underflow_err <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            if (w_issue && !wb_valid)
                r_outstanding <= r_outstanding + 4'd1;
            else if (!w_issue && wb_valid && (r_outstanding != 4'd0))
                r_outstanding <= r_outstanding - 4'd1;
            if (wb_valid && (r_outstanding == 4'd0))
                r_wb_underflow_err <= 1'b1;
            if (w_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign PC_write         = !w_stall;
    assign IF_ID_write      = !w_stall;
    assign control_op       = w_stall;
    assign outstanding      = r_outstanding;
    assign stall_cycles     = r_stall_cycles;
    assign wb_underflow_err = r_wb_underflow_err;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Self-checking bench for scoreboard_hazard_unit: hazard table, directed sequences, random vs model.
module tb_scoreboard_hazard_unit;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int MAXO = 2;
    localparam int SMAX = 15;

    typedef struct {
        bit       rstn, valid, use1, use2, rw, mr, flush, wbv;
        bit [4:0] rs1, rs2, rd, wbrd;
        bit [1:0] cause;
    } vec_t;

    logic       clk, reset_n, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic       flush, wb_valid, PC_write, IF_ID_write, control_op, wb_underflow_err;
    logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic [1:0] stall_cause;
    logic [3:0] outstanding, stall_cycles;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] obs_cause;

    bit pend[32];
    int cnt, scnt;
    bit err;

    scoreboard_hazard_unit #(.REG_ADDR_W(5), .MAX_OUTSTANDING(MAXO), .STALL_CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_use_rs1(id_use_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .control_op(control_op),
        .stall_cause(stall_cause), .outstanding(outstanding),
        .stall_cycles(stall_cycles), .wb_underflow_err(wb_underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(bit valid, bit use1, bit [4:0] rs1, bit use2, bit [4:0] rs2,
                                 bit rw, bit [4:0] rd, bit mr, bit fl, bit wbv, bit [4:0] wbrd,
                                 bit [1:0] cause);
        vec_t v;
        v.rstn = 1'b1; v.valid = valid; v.use1 = use1; v.rs1 = rs1; v.use2 = use2; v.rs2 = rs2;
        v.rw = rw; v.rd = rd; v.mr = mr; v.flush = fl; v.wbv = wbv; v.wbrd = wbrd; v.cause = cause;
        return v;
    endfunction

    function automatic vec_t idle();
        return mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t load(bit [4:0] rd);
        return mkv(1, 0, 0, 0, 0, 1, rd, 1, 0, 0, 0, 0);
    endfunction
    function automatic vec_t use1(bit [4:0] r);
        return mkv(1, 1, r, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic drive(input vec_t v);
        reset_n = v.rstn; id_valid = v.valid; id_use_rs1 = v.use1; id_rs1 = v.rs1;
        id_use_rs2 = v.use2; id_rs2 = v.rs2; id_reg_write = v.rw; id_rd = v.rd;
        id_mem_read = v.mr; flush = v.flush; wb_valid = v.wbv; wb_rd = v.wbrd;
    endtask

    // Reference model: a register is "busy" while a load to it is in flight.
    function automatic bit busy(bit [4:0] r, vec_t v);
        if (r == 0 || !pend[r]) return 1'b0;
        if (BYP && v.wbv && v.wbrd == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit [1:0] model_cause(vec_t v);
        bit raw, waw, st;
        if (!v.rstn || !v.valid || v.flush) return 2'b00;
        raw = (v.use1 && busy(v.rs1, v)) || (v.use2 && busy(v.rs2, v));
        waw = v.rw && busy(v.rd, v);
        st  = v.mr && cnt == MAXO && !(BYP && v.wbv && cnt > 0);
        if (raw) return 2'b01;
        if (waw) return 2'b10;
        if (st)  return 2'b11;
        return 2'b00;
    endfunction

    function automatic void model_update(vec_t v, bit [1:0] cause);
        bit issue;
        if (!v.rstn) begin
            foreach (pend[i]) pend[i] = 1'b0;
            cnt = 0; scnt = 0; err = 1'b0;
            return;
        end
        issue = v.valid && !v.flush && cause == 2'b00 && v.mr;
        if (v.wbv) begin
            pend[v.wbrd] = 1'b0;
            if (cnt == 0) err = 1'b1;
        end
        if (issue && v.rd != 0) pend[v.rd] = 1'b1;
        if (issue && !v.wbv) cnt++;
        else if (v.wbv && !issue && cnt > 0) cnt--;
        if (cause != 2'b00 && scnt < SMAX) scnt++;
    endfunction

    // One clock: drive on the falling edge, check outputs, then check state after the rising edge.
    task automatic step(input vec_t v);
        bit [1:0] exp;
        @(negedge clk);
        drive(v);
        #1;
        exp = model_cause(v);
        check("stall_cause", stall_cause, exp);
        check("PC_write", PC_write, exp == 2'b00);
        check("IF_ID_write", IF_ID_write, exp == 2'b00);
        check("control_op", control_op, exp != 2'b00);
        obs_cause = stall_cause;
        @(posedge clk);
        model_update(v, exp);
        #1;
        check("outstanding", outstanding, cnt);
        check("stall_cycles", stall_cycles, scnt);
        check("wb_underflow_err", wb_underflow_err, err);
    endtask

    task automatic do_reset();
        vec_t v;
        v = use1(5);
        v.rstn = 1'b0;
        step(v);
        step(v);
    endtask

    vec_t tbl[14];

    initial begin
        vec_t v;
        int   n;
        drive(idle());
        reset_n = 1'b0;

        // Hazard table against a fixed state: x5 and x9 pending, two loads in flight.
        tbl[0]  = mkv(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        tbl[1]  = mkv(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        tbl[2]  = mkv(1, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 2'b01);
        tbl[3]  = mkv(1, 0, 5, 0, 9, 0, 0, 0, 0, 0, 0, 2'b00);
        tbl[4]  = mkv(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 2'b10);
        tbl[5]  = mkv(1, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 2'b00);
        tbl[6]  = mkv(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 2'b11);
        tbl[7]  = mkv(1, 1, 5, 0, 0, 1, 9, 1, 0, 0, 0, 2'b01);
        tbl[8]  = mkv(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 2'b10);
        tbl[9]  = mkv(1, 1, 5, 1, 9, 1, 9, 1, 1, 0, 0, 2'b00);
        tbl[10] = mkv(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        tbl[11] = mkv(1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 5, BYP ? 2'b00 : 2'b01);
        tbl[12] = mkv(1, 0, 0, 0, 0, 1, 3, 1, 0, 1, 5, BYP ? 2'b00 : 2'b11);
        tbl[13] = mkv(1, 1, 6, 1, 7, 1, 6, 0, 0, 0, 0, 2'b00);

        do_reset();
        step(load(5));
        step(load(9));
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("tbl%0d_cause", i), stall_cause, tbl[i].cause);
            check($sformatf("tbl%0d_ctrl", i), control_op, tbl[i].cause != 2'b00);
            check($sformatf("tbl%0d_pcw", i), PC_write, tbl[i].cause == 2'b00);
            drive(idle());
        end

        // Load x5 then dependent use; writeback on the third dependent cycle.
        do_reset();
        step(load(5));
        check("seq1_out_after_load", outstanding, 1);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            v = use1(5);
            v.wbv = (k == 2);
            v.wbrd = 5;
            step(v);
            if (obs_cause == 2'b01) n++;
        end
        check("seq1_raw_cycles", n, BYP ? 2 : 3);
        check("seq1_stall_cycles", stall_cycles, BYP ? 2 : 3);
        check("seq1_out_final", outstanding, 0);

        // Load to x0 counts as in flight but never blocks a reader of x0.
        do_reset();
        step(load(0));
        step(use1(0));
        check("seq2_x0_cause", obs_cause, 0);
        check("seq2_out_inflight", outstanding, 1);
        v = idle(); v.wbv = 1'b1; v.wbrd = 0;
        step(v);
        check("seq2_out_done", outstanding, 0);
        check("seq2_err", wb_underflow_err, 0);

        // Structural limit with two loads in flight.
        do_reset();
        step(load(6));
        step(load(7));
        check("seq3_out_full", outstanding, 2);
        step(load(8));
        check("seq3_struct", obs_cause, 2'b11);
        step(load(8));
        v = load(8); v.wbv = 1'b1; v.wbrd = 6;
        step(v);
        check("seq3_wb_cycle", obs_cause, BYP ? 2'b00 : 2'b11);
        step(load(8));
        check("seq3_out_after", outstanding, 2);
        step(use1(8));
        check("seq3_x8_pending", obs_cause, 2'b01);

        // WAW against a pending load, masked by flush.
        do_reset();
        step(load(9));
        v = mkv(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        step(v);
        check("seq4_waw", obs_cause, 2'b10);
        v.flush = 1'b1;
        step(v);
        check("seq4_flush", obs_cause, 2'b00);
        check("seq4_out_flush", outstanding, 1);
        v.flush = 1'b0; v.wbv = 1'b1; v.wbrd = 9;
        step(v);
        check("seq4_wb_cycle", obs_cause, BYP ? 2'b00 : 2'b10);
        v.wbv = 1'b0;
        step(v);
        check("seq4_after_wb", obs_cause, 2'b00);

        // Saturation of the stall counter over 2**4+5 stalled cycles.
        do_reset();
        step(load(5));
        for (int k = 0; k < 21; k++) step(use1(5));
        check("sat_stall_cycles", stall_cycles, 15);

        // Underflow: drain the one in-flight load, then one extra writeback.
        v = idle(); v.wbv = 1'b1; v.wbrd = 5;
        step(v);
        check("uf_no_err_yet", wb_underflow_err, 0);
        v.wbrd = 3;
        step(v);
        check("uf_err_set", wb_underflow_err, 1);
        check("uf_out_zero", outstanding, 0);
        for (int k = 0; k < 3; k++) step(idle());
        check("uf_err_sticky", wb_underflow_err, 1);
        do_reset();
        check("uf_err_cleared", wb_underflow_err, 0);
        check("rst_out_cleared", outstanding, 0);
        check("rst_stall_cleared", stall_cycles, 0);

        // Random traffic on a small register window against the model.
        for (int k = 0; k < 600; k++) begin
            v.rstn  = $urandom_range(0, 99) != 0;
            v.valid = $urandom_range(0, 9) < 8;
            v.use1  = $urandom_range(0, 1) != 0;
            v.use2  = $urandom_range(0, 1) != 0;
            v.rs1   = 5'($urandom_range(0, 7));
            v.rs2   = 5'($urandom_range(0, 7));
            v.rd    = 5'($urandom_range(0, 7));
            v.mr    = $urandom_range(0, 9) < 3;
            v.rw    = v.mr || ($urandom_range(0, 1) != 0);
            v.flush = $urandom_range(0, 9) == 0;
            v.wbv   = $urandom_range(0, 9) < 3;
            v.wbrd  = 5'($urandom_range(0, 7));
            v.cause = 2'b00;
            step(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
